// File: rtl/sift_pkg.sv
// Shared SIFT definitions: DoG sample width/type and coordinate width helper.
package sift_pkg;

    localparam int unsigned DOG_DW = 9;

    typedef logic signed [DOG_DW-1:0] dog_t;

    // Width of a counter that spans 0..n-1; never less than one bit.
    function automatic int unsigned coord_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dog_line_buffer.sv
// Circular line buffer: data_o is the sample written DEPTH enables ago.
module dog_line_buffer
    import sift_pkg::*;
#(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned DW    = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o
);

    localparam int unsigned AW = coord_w(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Read-before-write at the pointer gives exactly DEPTH enables of delay.
    assign data_o = mem_q[ptr_q];

    // Pointer advance with wrap at DEPTH-1.
    always_comb begin
        ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end

    // Pointer register; only the pointer is reset, RAM contents are not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

    // RAM write on every accepted sample.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dog_neighbor_window.sv
// 6-connected 3-D neighbourhood builder over previous/current/next DoG scales.
module dog_neighbor_window
    import sift_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned DW    = DOG_DW
) (
    input  logic                       iclk,
    input  logic                       irst,
    input  logic                       iValid,
    input  logic                       iSof,
    input  logic signed [DW-1:0]       iData_pre,
    input  logic signed [DW-1:0]       iData_cur,
    input  logic signed [DW-1:0]       iData_next,
    output logic                       oValid,
    output logic [$clog2(IMG_W)-1:0]   oX,
    output logic [$clog2(IMG_H)-1:0]   oY,
    output logic signed [DW-1:0]       oData_center,
    output logic signed [DW-1:0]       oData_right,
    output logic signed [DW-1:0]       oData_left,
    output logic signed [DW-1:0]       oData_bot,
    output logic signed [DW-1:0]       oData_top,
    output logic signed [DW-1:0]       oData_next,
    output logic signed [DW-1:0]       oData_pre
);

    localparam int unsigned XW = coord_w(IMG_W);
    localparam int unsigned YW = coord_w(IMG_H);

    logic [XW-1:0] col_q, col_d, c_eff;
    logic [YW-1:0] row_q, row_d, r_eff;
    logic          win_ok;

    // Line-buffer taps (combinational reads) and pixel delay registers.
    logic [DW-1:0]        cur_l1;   // cur(c, r-1)
    logic [DW-1:0]        cur_l2;   // cur(c-1, r-2)
    logic [DW-1:0]        pre_l1;   // pre(c, r-1)
    logic [DW-1:0]        nxt_l1;   // next(c, r-1)
    logic signed [DW-1:0] ctr_q;    // cur(c-1, r-1)
    logic signed [DW-1:0] lft_q;    // cur(c-2, r-1)
    logic signed [DW-1:0] bot_q;    // cur(c-1, r)
    logic signed [DW-1:0] pre_q;    // pre(c-1, r-1)
    logic signed [DW-1:0] nxt_q;    // next(c-1, r-1)

    logic                 ovalid_q;
    logic [XW-1:0]        ox_q;
    logic [YW-1:0]        oy_q;
    logic signed [DW-1:0] ocenter_q, oright_q, oleft_q, obot_q, otop_q, onext_q, opre_q;

    // Position of the accepted pixel, next counter values and window gating.
    always_comb begin
        c_eff  = iSof ? '0 : col_q;
        r_eff  = iSof ? '0 : row_q;
        col_d  = col_q;
        row_d  = row_q;
        if (iValid) begin
            if (c_eff == XW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (r_eff == YW'(IMG_H - 1)) ? '0 : r_eff + 1'b1;
            end else begin
                col_d = c_eff + 1'b1;
                row_d = r_eff;
            end
        end
        win_ok = iValid && (c_eff >= XW'(2)) && (r_eff >= YW'(2));
    end

    // Raster counters.
    always_ff @(posedge iclk) begin
        if (irst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    dog_line_buffer #(
        .DEPTH (IMG_W),
        .DW    (DW)
    ) u_lb_cur1 (
        .clk_i  (iclk),
        .rst_i  (irst),
        .en_i   (iValid),
        .data_i (iData_cur),
        .data_o (cur_l1)
    );

    // Fed from the centre tap so its output already sits one pixel back.
    dog_line_buffer #(
        .DEPTH (IMG_W),
        .DW    (DW)
    ) u_lb_cur2 (
        .clk_i  (iclk),
        .rst_i  (irst),
        .en_i   (iValid),
        .data_i (ctr_q),
        .data_o (cur_l2)
    );

    dog_line_buffer #(
        .DEPTH (IMG_W),
        .DW    (DW)
    ) u_lb_pre (
        .clk_i  (iclk),
        .rst_i  (irst),
        .en_i   (iValid),
        .data_i (iData_pre),
        .data_o (pre_l1)
    );

    dog_line_buffer #(
        .DEPTH (IMG_W),
        .DW    (DW)
    ) u_lb_next (
        .clk_i  (iclk),
        .rst_i  (irst),
        .en_i   (iValid),
        .data_i (iData_next),
        .data_o (nxt_l1)
    );

    // Pixel shift registers; they move only with accepted samples.
    always_ff @(posedge iclk) begin
        if (irst) begin
            ctr_q <= '0;
            lft_q <= '0;
            bot_q <= '0;
            pre_q <= '0;
            nxt_q <= '0;
        end else if (iValid) begin
            ctr_q <= cur_l1;
            lft_q <= ctr_q;
            bot_q <= iData_cur;
            pre_q <= pre_l1;
            nxt_q <= nxt_l1;
        end
    end

    // Output registers; they hold whenever no interior window completes.
    always_ff @(posedge iclk) begin
        if (irst) begin
            ovalid_q  <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
            ocenter_q <= '0;
            oright_q  <= '0;
            oleft_q   <= '0;
            obot_q    <= '0;
            otop_q    <= '0;
            onext_q   <= '0;
            opre_q    <= '0;
        end else begin
            ovalid_q <= win_ok;
            if (win_ok) begin
                ox_q      <= c_eff - 1'b1;
                oy_q      <= r_eff - 1'b1;
                ocenter_q <= ctr_q;
                oright_q  <= cur_l1;
                oleft_q   <= lft_q;
                obot_q    <= bot_q;
                otop_q    <= cur_l2;
                onext_q   <= nxt_q;
                opre_q    <= pre_q;
            end
        end
    end

    assign oValid       = ovalid_q;
    assign oX           = ox_q;
    assign oY           = oy_q;
    assign oData_center = ocenter_q;
    assign oData_right  = oright_q;
    assign oData_left   = oleft_q;
    assign oData_bot    = obot_q;
    assign oData_top    = otop_q;
    assign oData_next   = onext_q;
    assign oData_pre    = opre_q;

endmodule

// File: tb/tb_dog_neighbor_window.sv
// Directed bench for dog_neighbor_window on an 8x6 image.
module tb_dog_neighbor_window;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 9;

    logic                 iclk = 1'b0;
    logic                 irst;
    logic                 iValid;
    logic                 iSof;
    logic signed [DW-1:0] iData_pre, iData_cur, iData_next;
    logic                 oValid;
    logic [2:0]           oX;
    logic [2:0]           oY;
    logic signed [DW-1:0] oData_center, oData_right, oData_left, oData_bot;
    logic signed [DW-1:0] oData_top, oData_next, oData_pre;

    dog_neighbor_window #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (DW)
    ) dut (
        .iclk         (iclk),
        .irst         (irst),
        .iValid       (iValid),
        .iSof         (iSof),
        .iData_pre    (iData_pre),
        .iData_cur    (iData_cur),
        .iData_next   (iData_next),
        .oValid       (oValid),
        .oX           (oX),
        .oY           (oY),
        .oData_center (oData_center),
        .oData_right  (oData_right),
        .oData_left   (oData_left),
        .oData_bot    (oData_bot),
        .oData_top    (oData_top),
        .oData_next   (oData_next),
        .oData_pre    (oData_pre)
    );

    always #5 iclk = ~iclk;

    int total = 0;
    int bad   = 0;

    int fc [H][W];
    int fp [H][W];
    int fn [H][W];

    int hold_c;
    int n_out;
    int first_x, first_y, first_c, first_r, first_l, first_t, first_b, first_p, first_n;
    int last_x, last_y, last_c;
    int ext_c, ext_r, ext_l, ext_t, ext_b;
    int n_sum;

    task automatic check(input string tag, input integer obs, input integer exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_ramp(input int off);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                fc[y][x] = 8 * y + x + off;
                fp[y][x] = fc[y][x] - 100;
                fn[y][x] = fc[y][x] + 100;
            end
        end
    endtask

    task automatic do_reset();
        irst   = 1'b1;
        iValid = 1'b0;
        iSof   = 1'b0;
        @(posedge iclk);
        #1;
        irst   = 1'b0;
        hold_c = 0;
        check("rst_valid", oValid, 0);
        check("rst_x", oX, 0);
        check("rst_y", oY, 0);
        check("rst_center", oData_center, 0);
        check("rst_top", oData_top, 0);
        check("rst_pre", oData_pre, 0);
    endtask

    // Streams the first npix raster pixels of the loaded frame and checks every cycle.
    task automatic stream(input int npix, input bit sof, input int gap_pct);
        int x, y;
        bit exp_v;
        n_out = 0;
        for (int k = 0; k < npix; k++) begin
            x = k % W;
            y = k / W;
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                iValid = 1'b0;
                iSof   = 1'b0;
                @(posedge iclk);
                #1;
                check("idle_valid", oValid, 0);
                check("idle_hold", oData_center, hold_c);
            end
            iValid     = 1'b1;
            iSof       = sof && (k == 0);
            iData_cur  = DW'(fc[y][x]);
            iData_pre  = DW'(fp[y][x]);
            iData_next = DW'(fn[y][x]);
            @(posedge iclk);
            #1;
            exp_v = (x >= 2) && (y >= 2);
            check("valid", oValid, exp_v);
            if (exp_v) begin
                check("x", oX, x - 1);
                check("y", oY, y - 1);
                check("center", oData_center, fc[y-1][x-1]);
                check("right", oData_right, fc[y-1][x]);
                check("left", oData_left, fc[y-1][x-2]);
                check("top", oData_top, fc[y-2][x-1]);
                check("bot", oData_bot, fc[y][x-1]);
                check("pre", oData_pre, fp[y-1][x-1]);
                check("next", oData_next, fn[y-1][x-1]);
                hold_c = fc[y-1][x-1];
            end
            if (oValid === 1'b1) begin
                n_out++;
                if (n_out == 1) begin
                    first_x = oX;
                    first_y = oY;
                    first_c = oData_center;
                    first_r = oData_right;
                    first_l = oData_left;
                    first_t = oData_top;
                    first_b = oData_bot;
                    first_p = oData_pre;
                    first_n = oData_next;
                end
                last_x = oX;
                last_y = oY;
                last_c = oData_center;
                if (oX == 3'd3 && oY == 3'd2) begin
                    ext_c = oData_center;
                    ext_r = oData_right;
                    ext_l = oData_left;
                    ext_t = oData_top;
                    ext_b = oData_bot;
                end
            end
        end
        iValid = 1'b0;
        iSof   = 1'b0;
    endtask

    initial begin
        irst       = 1'b1;
        iValid     = 1'b0;
        iSof       = 1'b0;
        iData_cur  = '0;
        iData_pre  = '0;
        iData_next = '0;
        hold_c     = 0;
        @(posedge iclk);
        do_reset();

        // Plain ramp frame, continuous input.
        load_ramp(0);
        stream(W * H, 1'b1, 0);
        check("f1_count", n_out, 24);
        check("f1_first_x", first_x, 1);
        check("f1_first_y", first_y, 1);
        check("f1_center", first_c, 9);
        check("f1_right", first_r, 10);
        check("f1_left", first_l, 8);
        check("f1_top", first_t, 1);
        check("f1_bot", first_b, 17);
        check("f1_pre", first_p, -91);
        check("f1_next", first_n, 109);
        check("f1_last_x", last_x, 6);
        check("f1_last_y", last_y, 4);
        check("f1_last_c", last_c, 38);

        // Same frame with idle gaps.
        stream(W * H, 1'b1, 40);
        check("gap_count", n_out, 24);
        check("gap_center", first_c, 9);
        check("gap_last_c", last_c, 38);

        // Signed extremes around centre (3,2).
        load_ramp(0);
        fc[2][3] = -256;
        fc[2][4] = 255;
        fc[2][2] = 255;
        fc[1][3] = 255;
        fc[3][3] = 255;
        stream(W * H, 1'b1, 0);
        check("ext_center", ext_c, -256);
        check("ext_right", ext_r, 255);
        check("ext_left", ext_l, 255);
        check("ext_top", ext_t, 255);
        check("ext_bot", ext_b, 255);

        // Reset after row 3, then a clean frame without iSof.
        load_ramp(20);
        stream(4 * W, 1'b1, 0);
        do_reset();
        load_ramp(0);
        stream(W * H, 1'b0, 0);
        check("rst_count", n_out, 24);
        check("rst_first_x", first_x, 1);
        check("rst_first_y", first_y, 1);
        check("rst_center", first_c, 9);
        check("rst_top", first_t, 1);

        // iSof reasserted at (5,2) of a partial frame.
        load_ramp(30);
        stream(2 * W + 5, 1'b1, 0);
        load_ramp(0);
        stream(W * H, 1'b1, 0);
        check("sof_count", n_out, 24);
        check("sof_first_x", first_x, 1);
        check("sof_first_y", first_y, 1);
        check("sof_center", first_c, 9);
        check("sof_top", first_t, 1);

        // Back-to-back frames, second ramp offset by 50.
        load_ramp(0);
        stream(W * H, 1'b1, 0);
        n_sum = n_out;
        check("b2b_f1_last", last_c, 38);
        load_ramp(50);
        stream(W * H, 1'b1, 0);
        n_sum += n_out;
        check("b2b_count", n_sum, 48);
        check("b2b_center", first_c, 59);
        check("b2b_top", first_t, 51);
        check("b2b_pre", first_p, -41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
